// File: rtl/uart_rx_packet.sv
// uart_rx_packet
// UART receiver and packet decoder for the ball-balancer command link.
// Recovers 8N1 bytes from an oversampled serial line and assembles
// HEADER, X_LO, X_HI, Y_LO, Y_HI packets into a new X/Y setpoint pair.
// Optional feature macro: CHECKSUM_EN adds a sixth byte holding the
// mod-256 sum of the four payload bytes; without it checksum_error is 0.

module uart_rx_packet #(
    parameter int          OVERSAMPLE = 16,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic        rx_in,
    output logic [15:0] set_x_out,
    output logic [15:0] set_y_out,
    output logic        packet_valid,
    output logic        framing_error,
    output logic        checksum_error
);

    localparam int CW = $clog2(OVERSAMPLE);

    // Tick count at which the start bit (half period) and the data/stop
    // bits (full period) are sampled.
    localparam logic [CW-1:0] TICK_HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] TICK_FULL_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP,
        BIT_BREAK
    } bit_state_t;

    typedef enum logic [2:0] {
        PKT_HUNT,
        PKT_X_LO,
        PKT_X_HI,
        PKT_Y_LO,
        PKT_Y_HI
`ifdef CHECKSUM_EN
        , PKT_CHK
`endif
    } pkt_state_t;

    // Synchronizer flops
    logic rx_meta_q, rx_meta_d;
    logic rx_sync_q, rx_sync_d;

    // Bit-level receiver state
    bit_state_t    bit_state_q, bit_state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_strobe_q, byte_strobe_d;
    logic          framing_error_q, framing_error_d;

    // Packet-level state and payload staging
    pkt_state_t    pkt_state_q, pkt_state_d;
    logic [7:0]    x_lo_q, x_lo_d;
    logic [7:0]    x_hi_q, x_hi_d;
    logic [7:0]    y_lo_q, y_lo_d;
`ifdef CHECKSUM_EN
    logic [7:0]    y_hi_q, y_hi_d;
    logic [7:0]    chk_sum;
    logic          checksum_error_q, checksum_error_d;
`endif

    // Published setpoints and completion strobe
    logic [15:0]   set_x_q, set_x_d;
    logic [15:0]   set_y_q, set_y_d;
    logic          packet_valid_q, packet_valid_d;

    // Two-flop synchronizer: the raw line is asynchronous to clk.
    always_comb begin
        rx_meta_d = rx_in;
        rx_sync_d = rx_meta_q;
    end

    // Synchronizer registers; reset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
        end
    end

    // Bit FSM next-state: only sample_tick edges move the receiver along.
    always_comb begin
        bit_state_d     = bit_state_q;
        tick_cnt_d      = tick_cnt_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        byte_strobe_d   = 1'b0;
        framing_error_d = 1'b0;

        if (sample_tick) begin
            case (bit_state_q)
                BIT_IDLE: begin
                    if (!rx_sync_q) begin
                        tick_cnt_d  = '0;
                        bit_state_d = BIT_START;
                    end
                end

                BIT_START: begin
                    if (tick_cnt_q == TICK_HALF_LAST) begin
                        tick_cnt_d = '0;
                        if (!rx_sync_q) begin
                            bit_idx_d   = 3'd0;
                            bit_state_d = BIT_DATA;
                        end else begin
                            bit_state_d = BIT_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end

                BIT_DATA: begin
                    if (tick_cnt_q == TICK_FULL_LAST) begin
                        tick_cnt_d         = '0;
                        shift_d[bit_idx_q] = rx_sync_q;
                        if (bit_idx_q == 3'd7) begin
                            bit_state_d = BIT_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end

                BIT_STOP: begin
                    if (tick_cnt_q == TICK_FULL_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_sync_q) begin
                            byte_strobe_d = 1'b1;
                            bit_state_d   = BIT_IDLE;
                        end else begin
                            framing_error_d = 1'b1;
                            bit_state_d     = BIT_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end

                BIT_BREAK: begin
                    if (rx_sync_q) begin
                        bit_state_d = BIT_IDLE;
                    end
                end

                default: begin
                    bit_state_d = BIT_IDLE;
                    tick_cnt_d  = '0;
                end
            endcase
        end
    end

    // Bit FSM registers; reset abandons any byte in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_state_q     <= BIT_IDLE;
            tick_cnt_q      <= '0;
            bit_idx_q       <= 3'd0;
            shift_q         <= 8'h00;
            byte_strobe_q   <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            bit_state_q     <= bit_state_d;
            tick_cnt_q      <= tick_cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            byte_strobe_q   <= byte_strobe_d;
            framing_error_q <= framing_error_d;
        end
    end

`ifdef CHECKSUM_EN
    // Running sum of the staged payload, compared with the trailing byte.
    always_comb begin
        chk_sum = x_lo_q + x_hi_q + y_lo_q + y_hi_q;
    end
`endif

    // Packet FSM next-state: consumes one received byte per strobe and
    // only publishes the setpoints once a whole packet has been accepted.
    always_comb begin
        pkt_state_d    = pkt_state_q;
        x_lo_d         = x_lo_q;
        x_hi_d         = x_hi_q;
        y_lo_d         = y_lo_q;
        set_x_d        = set_x_q;
        set_y_d        = set_y_q;
        packet_valid_d = 1'b0;
`ifdef CHECKSUM_EN
        y_hi_d           = y_hi_q;
        checksum_error_d = 1'b0;
`endif

        if (framing_error_q) begin
            pkt_state_d = PKT_HUNT;
        end else if (byte_strobe_q) begin
            case (pkt_state_q)
                PKT_HUNT: begin
                    if (shift_q == HEADER) begin
                        pkt_state_d = PKT_X_LO;
                    end
                end

                PKT_X_LO: begin
                    x_lo_d      = shift_q;
                    pkt_state_d = PKT_X_HI;
                end

                PKT_X_HI: begin
                    x_hi_d      = shift_q;
                    pkt_state_d = PKT_Y_LO;
                end

                PKT_Y_LO: begin
                    y_lo_d      = shift_q;
                    pkt_state_d = PKT_Y_HI;
                end

                PKT_Y_HI: begin
`ifdef CHECKSUM_EN
                    y_hi_d      = shift_q;
                    pkt_state_d = PKT_CHK;
`else
                    set_x_d        = {x_hi_q, x_lo_q};
                    set_y_d        = {shift_q, y_lo_q};
                    packet_valid_d = 1'b1;
                    pkt_state_d    = PKT_HUNT;
`endif
                end

`ifdef CHECKSUM_EN
                PKT_CHK: begin
                    if (shift_q == chk_sum) begin
                        set_x_d        = {x_hi_q, x_lo_q};
                        set_y_d        = {y_hi_q, y_lo_q};
                        packet_valid_d = 1'b1;
                    end else begin
                        checksum_error_d = 1'b1;
                    end
                    pkt_state_d = PKT_HUNT;
                end
`endif

                default: begin
                    pkt_state_d = PKT_HUNT;
                end
            endcase
        end
    end

    // Packet FSM and output registers; reset drops any partial packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_state_q    <= PKT_HUNT;
            x_lo_q         <= 8'h00;
            x_hi_q         <= 8'h00;
            y_lo_q         <= 8'h00;
            set_x_q        <= 16'h0000;
            set_y_q        <= 16'h0000;
            packet_valid_q <= 1'b0;
        end else begin
            pkt_state_q    <= pkt_state_d;
            x_lo_q         <= x_lo_d;
            x_hi_q         <= x_hi_d;
            y_lo_q         <= y_lo_d;
            set_x_q        <= set_x_d;
            set_y_q        <= set_y_d;
            packet_valid_q <= packet_valid_d;
        end
    end

`ifdef CHECKSUM_EN
    // Checksum-only registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_hi_q           <= 8'h00;
            checksum_error_q <= 1'b0;
        end else begin
            y_hi_q           <= y_hi_d;
            checksum_error_q <= checksum_error_d;
        end
    end

    assign checksum_error = checksum_error_q;
`else
    assign checksum_error = 1'b0;
`endif

    assign set_x_out     = set_x_q;
    assign set_y_out     = set_y_q;
    assign packet_valid  = packet_valid_q;
    assign framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx_packet.sv
// Testbench for uart_rx_packet: serial byte driver, byte-level packet
// reference model and pulse counters. Build with +define+CHECKSUM_EN to
// exercise the six-byte checksummed packet format.

module tb_uart_rx_packet;

   localparam int         OVERSAMPLE = 16;
   localparam int         TICK_DIV   = 4;
   localparam int         BIT_CLKS   = OVERSAMPLE * TICK_DIV;
   localparam logic [7:0] HEADER     = 8'hA5;
`ifdef CHECKSUM_EN
   localparam int         PKT_LEN    = 6;
`else
   localparam int         PKT_LEN    = 5;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sampleTick = 1'b0;
   logic        rxIn = 1'b1;
   logic [15:0] setXOut;
   logic [15:0] setYOut;
   logic        packetValid;
   logic        framingError;
   logic        checksumError;

   int checkCount = 0;
   int passCount  = 0;
   int tickDiv    = 0;

   // Observed pulse counts (cycles high) and model expectations
   int pvCount = 0;
   int feCount = 0;
   int ceCount = 0;
   int expPv   = 0;
   int expFe   = 0;
   int expCe   = 0;
   logic [15:0] expX = 16'h0000;
   logic [15:0] expY = 16'h0000;
   logic [7:0]  pktBuf[$];

   uart_rx_packet #(
      .OVERSAMPLE(OVERSAMPLE),
      .HEADER(HEADER)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sample_tick(sampleTick),
      .rx_in(rxIn),
      .set_x_out(setXOut),
      .set_y_out(setYOut),
      .packet_valid(packetValid),
      .framing_error(framingError),
      .checksum_error(checksumError)
   );

   // Free-running 100 MHz style clock
   initial forever #5 clk = ~clk;

   // sample_tick: one clock high out of every TICK_DIV
   initial forever begin
      @(negedge clk);
      tickDiv = (tickDiv + 1) % TICK_DIV;
      sampleTick = (tickDiv == 0);
   end

   // Count every cycle each strobe is high, so a stretched pulse shows up
   // as an extra count.
   initial forever begin
      @(negedge clk);
      if (packetValid) pvCount++;
      if (framingError) feCount++;
      if (checksumError) ceCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".packet_valid_pulses"}, pvCount, expPv);
      checkOutput({tag, ".framing_error_pulses"}, feCount, expFe);
      checkOutput({tag, ".checksum_error_pulses"}, ceCount, expCe);
      checkOutput({tag, ".set_x_out"}, setXOut, expX);
      checkOutput({tag, ".set_y_out"}, setYOut, expY);
   endtask

   // Reference model: collects bytes from a HEADER byte onward and judges
   // the packet once PKT_LEN bytes are in hand.
   task automatic modelByte(input logic [7:0] b, input bit badStop);
      int sum;
      if (badStop) begin
         expFe++;
         pktBuf.delete();
      end else if (pktBuf.size() != 0 || b == HEADER) begin
         pktBuf.push_back(b);
         if (pktBuf.size() == PKT_LEN) begin
            sum = (int'(pktBuf[1]) + int'(pktBuf[2]) + int'(pktBuf[3]) + int'(pktBuf[4])) % 256;
            if (PKT_LEN == 5 || int'(pktBuf[PKT_LEN-1]) == sum) begin
               expX = {pktBuf[2], pktBuf[1]};
               expY = {pktBuf[4], pktBuf[3]};
               expPv++;
            end else begin
               expCe++;
            end
            pktBuf.delete();
         end
      end
   endtask

   // Drive one 8N1 byte LSB first, optionally with a low stop bit (followed
   // by one bit period of idle line), then gapBits idle bit periods.
   task automatic applyStimulus(input logic [7:0] b, input bit badStop, input int gapBits);
      rxIn = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxIn = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rxIn = !badStop;
      repeat (BIT_CLKS) @(negedge clk);
      rxIn = 1'b1;
      if (badStop) repeat (BIT_CLKS) @(negedge clk);
      repeat (gapBits * BIT_CLKS) @(negedge clk);
      modelByte(b, badStop);
   endtask

   // Whole packet; chkXor nonzero corrupts the checksum byte.
   task automatic sendPacket(input logic [15:0] x, input logic [15:0] y,
                             input logic [7:0] chkXor, input bit randomGaps);
      logic [7:0] bytes[6];
      int sum;
      bytes[0] = HEADER;
      bytes[1] = x[7:0];
      bytes[2] = x[15:8];
      bytes[3] = y[7:0];
      bytes[4] = y[15:8];
      sum = (int'(bytes[1]) + int'(bytes[2]) + int'(bytes[3]) + int'(bytes[4])) % 256;
      bytes[5] = 8'(sum) ^ chkXor;
      for (int i = 0; i < PKT_LEN; i++) begin
         applyStimulus(bytes[i], 1'b0, randomGaps ? int'($urandom_range(0, 1)) : 0);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int kind;
      logic [7:0] corrupt;

      // Reset state, then a long idle line
      repeat (5) @(negedge clk);
      sampleTick = 1'b0;
      reset = 1'b0;
      checkAll("reset");
      repeat (100 * BIT_CLKS) @(negedge clk);
      checkAll("idle");

      // Basic packet X=1234, Y=5678
      sendPacket(16'h1234, 16'h5678, 8'h00, 1'b0);
      checkAll("pkt1234");

`ifdef CHECKSUM_EN
      // Checksum 0x15 instead of 0x14
      sendPacket(16'h1234, 16'h5678, 8'h01, 1'b0);
      checkAll("badchk");
`endif

      // Framing error mid-packet, then a packet carrying zero low bytes
      applyStimulus(8'hA5, 1'b0, 0);
      applyStimulus(8'h34, 1'b1, 1);
      checkAll("frame.err");
      sendPacket(16'hAB00, 16'hCD00, 8'h00, 1'b0);
      checkAll("frame.recover");

      // Quarter-bit glitch on the idle line
      rxIn = 1'b0;
      repeat (BIT_CLKS / 4) @(negedge clk);
      rxIn = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      checkAll("glitch");
      sendPacket(16'hBEEF, 16'hA5A5, 8'h00, 1'b0);
      checkAll("glitch.recover");

      // Reset for one clock after the X_HI byte
      applyStimulus(8'hA5, 1'b0, 0);
      applyStimulus(8'h11, 1'b0, 0);
      applyStimulus(8'h22, 1'b0, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pktBuf.delete();
      expX = 16'h0000;
      expY = 16'h0000;
      checkAll("reset.mid");
      applyStimulus(8'h33, 1'b0, 0);
      applyStimulus(8'h44, 1'b0, 0);
      applyStimulus(8'hAA, 1'b0, 1);
      checkAll("reset.tail");
      sendPacket(16'h0F0F, 16'hF00D, 8'h00, 1'b0);
      checkAll("reset.recover");

      // Randomized mix: good packets (back-to-back or gapped), corrupted
      // checksums, stray bytes and framing errors
      for (int n = 0; n < 12; n++) begin
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: sendPacket(16'($urandom), 16'($urandom), 8'h00, 1'b1);
            1: begin
               corrupt = 8'($urandom_range(1, 255));
               sendPacket(16'($urandom), 16'($urandom), corrupt, 1'b1);
            end
            2: applyStimulus(8'($urandom), 1'b0, int'($urandom_range(0, 1)));
            default: applyStimulus(8'($urandom), 1'b1, 0);
         endcase
         repeat (4) @(negedge clk);
         checkAll($sformatf("rand%0d", n));
      end

      // Close out any dangling partial packet with a known good one
      repeat (PKT_LEN) applyStimulus(8'h00, 1'b1, 0);
      sendPacket(16'h2468, 16'h1357, 8'h00, 1'b0);
      checkAll("final");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/uart_rx_packet.md
# uart_rx_packet

UART receiver and packet decoder for the ball-balancer command link. Oversamples the serial line, recovers 8N1 bytes (LSB first), and assembles framed packets carrying a new X/Y setpoint for the PID controller. It is the host-to-board counterpart of the telemetry transmitter and presents each validated setpoint pair with a one-cycle strobe.

## Interface
- OVERSAMPLE, 16, sample_tick pulses per bit period; even, 4..32
- HEADER, 8'hA5, packet start byte
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sample_tick  input  1  one-clk-wide enable at OVERSAMPLE × baud rate
- rx_in  input  1  asynchronous serial line, idle high
- set_x_out  output  16  last accepted X setpoint
- set_y_out  output  16  last accepted Y setpoint
- packet_valid  output  1  one-clk pulse when set_x_out/set_y_out update
- framing_error  output  1  one-clk pulse on stop bit sampled low
- checksum_error  output  1  one-clk pulse on checksum mismatch (tied 0 without CHECKSUM_EN)

## Operation
- rx_in passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Bit FSM (advances only on clk edges where sample_tick=1):
  - IDLE: on synchronized rx=0, clear tick counter -> START.
  - START: after OVERSAMPLE/2 ticks, sample; 0 -> DATA (bit index 0, counter cleared); 1 -> IDLE (glitch, no error).
  - DATA: every OVERSAMPLE ticks sample into shift register at bit index, LSB first; after index 7 -> STOP.
  - STOP: after OVERSAMPLE ticks sample; 1 -> byte strobe, IDLE; 0 -> framing_error pulse, byte discarded, packet FSM to HUNT, -> BREAK.
  - BREAK: wait for sampled rx=1 on a tick -> IDLE.
- Packet FSM (advances on byte strobe): HUNT (byte == HEADER -> X_LO, else stay) -> X_LO -> X_HI -> Y_LO -> Y_HI -> [CHK] -> HUNT.
- Payload byte order: low byte first; X then Y. Payload held in staging registers; outputs untouched until packet completes.
- HEADER value inside payload is data; no resynchronization mid-packet.
- Completion: set_x_out/set_y_out load staging values and packet_valid pulses.

## Timing
- Reset values: set_x_out=0, set_y_out=0, packet_valid=0, framing_error=0, checksum_error=0; both FSMs IDLE/HUNT, counters 0.
- Reset at any point, including mid-byte or mid-packet, aborts all progress; partial packet discarded; effective on the same edge.
- rx_in to internal view: 2 clk latency.
- Byte strobe: clk edge after stop-bit sample tick.
- packet_valid, set_x_out/set_y_out update, and checksum_error all assert on the clk edge after the final byte strobe; pulses last exactly 1 clk.
- framing_error asserts on the clk edge after the failing stop-bit sample tick.
- Outputs hold between packets; back-to-back packets with no idle gap are accepted.
- sample_tick high during reset is ignored.
- Tick counter width ceil(log2(OVERSAMPLE)); wraps only via explicit clear.

## Configuration
- CHECKSUM_EN defined: packet has a sixth byte, CHK = (X_LO + X_HI + Y_LO + Y_HI) mod 256; match -> completion; mismatch -> checksum_error pulse, outputs unchanged, -> HUNT.
- CHECKSUM_EN undefined: no CHK state; packet completes on Y_HI; checksum_error tied 0.

## Test plan
- Reset, idle line, 100 bit periods -> all outputs 0, no pulses.
- OVERSAMPLE=16, sample_tick every 4 clk; send A5 34 12 78 56 (plus 14 with CHECKSUM_EN) -> set_x_out=16'h1234, set_y_out=16'h5678, single packet_valid pulse.
- With CHECKSUM_EN send A5 34 12 78 56 15 -> checksum_error pulse, outputs keep 1234/5678, no packet_valid.
- Send A5 34 with stop bit of 0x34 held low for 1 bit, then line high, then full valid packet 00 AB 00 CD -> framing_error pulse; next packet yields set_x_out=16'hAB00, set_y_out=16'hCD00.
- 0.25-bit low glitch on idle line -> no byte strobe, no error; subsequent packet decoded correctly.
- Assert reset for 1 clk after X_HI byte of a packet -> remaining bytes ignored until next A5, outputs 0, no packet_valid.
